param_bus_cpu: RTL and testbench

//  Parametrised common-bus CPU core; generalises the 8-bit design in data width and register count.

---
 rtl/param_bus_cpu.sv | 160 ++++++++++++++++
 tb/tb_param_bus_cpu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_cpu.sv
// Parametrised common-bus CPU core.
// The PC, IR, ALU operand latches, ALU result and register file all share one
// internal bus, and a multi-cycle control FSM drives it.
// Instructions arrive through a request/valid fetch handshake.
module param_bus_cpu #(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned RA_W     = $clog2(NUM_REGS),
  localparam int unsigned INSTR_W  = 3 + 2 * RA_W + DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               dbg_sel_pc,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_value,
  output logic               retire,
  output logic               halted,
  output logic               flag_z,
  output logic               flag_c
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SRC1   = 3'd2;
  localparam logic [2:0] S_SRC2   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_RETIRE = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_JNZ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic [2:0]         state, state_nxt;
  logic [DATA_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  src1, src2;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  bus;
  logic [DATA_W:0]    alu_wide;
  logic [DATA_W-1:0]  alu_res;

  logic [2:0]         op;
  logic [RA_W-1:0]    rd, rs;
  logic [DATA_W-1:0]  imm;

  assign op  = ir[INSTR_W-1 -: 3];
  assign rd  = ir[DATA_W+RA_W +: RA_W];
  assign rs  = ir[DATA_W +: RA_W];
  assign imm = ir[DATA_W-1:0];

  assign imem_addr = pc;
  assign dbg_value = dbg_sel_pc ? pc : regs[dbg_addr];
  assign alu_res   = alu_wide[DATA_W-1:0];

  // ALU: the extra top bit carries the ADD carry or the SUB borrow
  always_comb begin
    alu_wide = {1'b0, src2};
    case (op)
      OP_ADD:  alu_wide = {1'b0, src1} + {1'b0, src2};
      OP_SUB:  alu_wide = {1'b0, src1} - {1'b0, src2};
      OP_AND:  alu_wide = {1'b0, src1 & src2};
      default: alu_wide = {1'b0, src2};
    endcase
  end

  // Select the single bus driver for the current state
  always_comb begin
    bus = '0;
    case (state)
      S_FETCH: bus = pc;
      S_SRC1:  bus = regs[rd];
      S_SRC2:  bus = (op == OP_LDI || op == OP_JNZ) ? imm : regs[rs];
      S_WB:    bus = alu_res;
      default: bus = '0;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Control FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (imem_valid) state_nxt = S_SRC1;
      S_SRC1: begin
        if (op == OP_HALT)     state_nxt = S_HALTED;
        else if (op == OP_NOP) state_nxt = S_RETIRE;
        else                   state_nxt = S_SRC2;
      end
      S_SRC2:   state_nxt = S_WB;
      S_WB:     state_nxt = S_RETIRE;
      S_RETIRE: state_nxt = S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imem_req <= 1'b0;
      retire   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      imem_req <= (state_nxt == S_FETCH);
      retire   <= (state_nxt == S_RETIRE);
      halted   <= (state_nxt == S_HALTED);
    end
  end

  // Datapath: fetch, operand latches, register writeback, flags, branch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= '0;
      ir     <= '0;
      src1   <= '0;
      src2   <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir <= imem_data;
            pc <= pc + DATA_W'(1);
          end
        end
        S_SRC1: src1 <= bus;
        S_SRC2: src2 <= bus;
        S_WB: begin
          if (op >= OP_LDI && op <= OP_AND) regs[rd] <= bus;
          if (op >= OP_ADD && op <= OP_AND) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_wide[DATA_W];
          end
          // A taken branch overrides the PC already incremented at fetch
          if (op == OP_JNZ && src1 != '0) pc <= src2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bus_cpu.sv
// Self-checking bench for param_bus_cpu. Instructions are fed from a vector
// table and expectations are queued when each instruction is accepted.
module tb_param_bus_cpu;

  localparam int unsigned IW   = 15;
  localparam int unsigned IW16 = 25;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          imem_req, imem_valid, dbg_sel_pc, retire, halted, flag_z, flag_c;
  logic [7:0]    imem_addr, dbg_value;
  logic [IW-1:0] imem_data;
  logic [1:0]    dbg_addr;

  logic            req16, valid16, sel16, retire16, halted16, z16, c16;
  logic [15:0]     addr16, value16;
  logic [IW16-1:0] data16;
  logic [2:0]      daddr16;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] addr;
    logic [7:0] exp_rd;
    logic       exp_z;
    logic       exp_c;
    logic [7:0] exp_pc;
    int         lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[21];

  always #5 clock = ~clock;

  param_bus_cpu #(.DATA_W(8), .NUM_REGS(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .dbg_sel_pc(dbg_sel_pc),
    .dbg_addr(dbg_addr), .dbg_value(dbg_value), .retire(retire), .halted(halted),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  param_bus_cpu #(.DATA_W(16), .NUM_REGS(8)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .imem_req(req16), .imem_addr(addr16),
    .imem_valid(valid16), .imem_data(data16), .dbg_sel_pc(sel16),
    .dbg_addr(daddr16), .dbg_value(value16), .retire(retire16), .halted(halted16),
    .flag_z(z16), .flag_c(c16)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                              input logic [7:0] imm, input logic [7:0] addr,
                              input logic [7:0] exp_rd, input logic exp_z, input logic exp_c,
                              input logic [7:0] exp_pc);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.addr = addr;
    v.exp_rd = exp_rd; v.exp_z = exp_z; v.exp_c = exp_c; v.exp_pc = exp_pc;
    v.lat = (op == 3'd0) ? 1 : 3;
    return v;
  endfunction

  task automatic read_reg(input logic [1:0] r, output logic [7:0] val);
    dbg_sel_pc = 1'b0;
    dbg_addr   = r;
    #1;
    val = dbg_value;
  endtask

  task automatic read_pc(output logic [7:0] val);
    dbg_sel_pc = 1'b1;
    #1;
    val = dbg_value;
    dbg_sel_pc = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    imem_valid = 1'b0;
    valid16    = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 40) begin step(); n++; end
    check("req_seen", 32'(imem_req), 32'd1);
  endtask

  // Feed one instruction with optional stall, then score it at retire
  task automatic issue(input vec_t e, input int stall);
    int   lat;
    vec_t x;
    logic [7:0] v;
    wait_req();
    check("fetch_addr", 32'(imem_addr), 32'(e.addr));
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", 32'(imem_addr), 32'(e.addr));
      check("stall_retire", 32'(retire), 32'd0);
    end
    imem_data  = {e.op, e.rd, e.rs, e.imm};
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    imem_data  = '0;
    sb.push_back(e);
    lat = 0;
    while (!retire && lat < 20) begin step(); lat++; end
    if (!retire) begin
      tests++;
      fails++;
      $display("FAIL retire_timeout: got no retire expected retire at op %0d", e.op);
      void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      check("latency", 32'(lat), 32'(x.lat));
      read_reg(x.rd, v);
      check("reg_rd", 32'(v), 32'(x.exp_rd));
      check("flag_z", 32'(flag_z), 32'(x.exp_z));
      check("flag_c", 32'(flag_c), 32'(x.exp_c));
      read_pc(v);
      check("pc", 32'(v), 32'(x.exp_pc));
    end
  endtask

  task automatic run16(input logic [IW16-1:0] ins);
    int n;
    n = 0;
    while (!req16 && n < 40) begin step(); n++; end
    check("u16_req", 32'(req16), 32'd1);
    data16  = ins;
    valid16 = 1'b1;
    step();
    valid16 = 1'b0;
    n = 0;
    while (!retire16 && n < 20) begin step(); n++; end
    check("u16_retire", 32'(retire16), 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    int cyc;

    //      op    rd    rs    imm    addr   exp_rd z     c     pc
    tbl[0]  = mk(3'd1, 2'd0, 2'd0, 8'hF0, 8'h00, 8'hF0, 1'b0, 1'b0, 8'h01);
    tbl[1]  = mk(3'd1, 2'd1, 2'd0, 8'h20, 8'h01, 8'h20, 1'b0, 1'b0, 8'h02);
    tbl[2]  = mk(3'd3, 2'd0, 2'd1, 8'h00, 8'h02, 8'h10, 1'b0, 1'b1, 8'h03);
    tbl[3]  = mk(3'd1, 2'd2, 2'd0, 8'h03, 8'h03, 8'h03, 1'b0, 1'b1, 8'h04);
    tbl[4]  = mk(3'd1, 2'd3, 2'd0, 8'h03, 8'h04, 8'h03, 1'b0, 1'b1, 8'h05);
    tbl[5]  = mk(3'd4, 2'd2, 2'd3, 8'h00, 8'h05, 8'h00, 1'b1, 1'b0, 8'h06);
    tbl[6]  = mk(3'd4, 2'd2, 2'd3, 8'h00, 8'h06, 8'hFD, 1'b0, 1'b1, 8'h07);
    tbl[7]  = mk(3'd5, 2'd2, 2'd1, 8'h00, 8'h07, 8'h20, 1'b0, 1'b0, 8'h08);
    tbl[8]  = mk(3'd2, 2'd3, 2'd2, 8'h00, 8'h08, 8'h20, 1'b0, 1'b0, 8'h09);
    tbl[9]  = mk(3'd0, 2'd0, 2'd0, 8'h00, 8'h09, 8'h10, 1'b0, 1'b0, 8'h0A);
    tbl[10] = mk(3'd3, 2'd1, 2'd1, 8'h00, 8'h0A, 8'h40, 1'b0, 1'b0, 8'h0B);
    tbl[11] = mk(3'd4, 2'd1, 2'd1, 8'h00, 8'h0B, 8'h00, 1'b1, 1'b0, 8'h0C);
    tbl[12] = mk(3'd1, 2'd0, 2'd0, 8'h02, 8'h0C, 8'h02, 1'b1, 1'b0, 8'h0D);
    tbl[13] = mk(3'd1, 2'd1, 2'd0, 8'h01, 8'h0D, 8'h01, 1'b1, 1'b0, 8'h0E);
    tbl[14] = mk(3'd4, 2'd0, 2'd1, 8'h00, 8'h0E, 8'h01, 1'b0, 1'b0, 8'h0F);
    tbl[15] = mk(3'd6, 2'd0, 2'd0, 8'h0E, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h0E);
    tbl[16] = mk(3'd4, 2'd0, 2'd1, 8'h00, 8'h0E, 8'h00, 1'b1, 1'b0, 8'h0F);
    tbl[17] = mk(3'd6, 2'd0, 2'd0, 8'h0E, 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10);
    tbl[18] = mk(3'd1, 2'd3, 2'd0, 8'h01, 8'h10, 8'h01, 1'b1, 1'b0, 8'h11);
    tbl[19] = mk(3'd6, 2'd3, 2'd0, 8'hFF, 8'h11, 8'h01, 1'b1, 1'b0, 8'hFF);
    tbl[20] = mk(3'd0, 2'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00);

    reset_n    = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    dbg_sel_pc = 1'b0;
    dbg_addr   = '0;
    valid16    = 1'b0;
    data16     = '0;
    sel16      = 1'b0;
    daddr16    = 3'd7;

    // T1: reset values, then LDI r1,0x05 with valid held from reset release
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_flags", 32'({flag_z, flag_c}), 32'd0);
    read_pc(v);
    check("rst_pc", 32'(v), 32'd0);
    imem_data  = {3'd1, 2'd1, 2'd0, 8'h05};
    imem_valid = 1'b1;
    reset_n    = 1'b1;
    cyc = 0;
    while (!retire && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 1) check("t1_req", 32'(imem_req), 32'd1);
      if (cyc == 2) imem_valid = 1'b0;
    end
    check("t1_retire_cycle", 32'(cyc), 32'd5);
    read_reg(2'd1, v);
    check("t1_r1", 32'(v), 32'h05);
    read_pc(v);
    check("t1_pc", 32'(v), 32'd1);
    step();
    check("t1_retire_pulse", 32'(retire), 32'd0);

    // T2-T4 plus MOV/AND/NOP/rd==rs/PC wrap from the vector table
    apply_reset();
    for (int i = 0; i < 21; i++) issue(tbl[i], i % 3);
    check("sb_empty", 32'(sb.size()), 32'd0);

    // T5: stalled fetch then HALT; later valids are ignored
    wait_req();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_req", 32'(imem_req), 32'd1);
      check("t5_retire", 32'(retire), 32'd0);
      read_pc(v);
      check("t5_pc_stable", 32'(v), 32'd0);
    end
    imem_data  = {3'd7, 2'd0, 2'd0, 8'h00};
    imem_valid = 1'b1;
    step();
    imem_data = {3'd1, 2'd0, 2'd0, 8'hAA};
    step();
    check("t5_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_halt_req", 32'(imem_req), 32'd0);
      check("t5_halt_retire", 32'(retire), 32'd0);
      check("t5_halt_hold", 32'(halted), 32'd1);
    end
    imem_valid = 1'b0;
    read_reg(2'd0, v);
    check("t5_r0_kept", 32'(v), 32'd0);
    read_pc(v);
    check("t5_pc_kept", 32'(v), 32'd1);

    // T6: reset asserted during WB of ADD aborts the write
    apply_reset();
    issue(mk(3'd1, 2'd1, 2'd0, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 8'h01), 0);
    wait_req();
    imem_data  = {3'd3, 2'd1, 2'd1, 8'h00};
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    step();
    read_reg(2'd1, v);
    check("t6_pre_wb_r1", 32'(v), 32'h07);
    reset_n = 1'b0;
    #1;
    read_reg(2'd1, v);
    check("t6_r1_cleared", 32'(v), 32'd0);
    check("t6_flag_c", 32'(flag_c), 32'd0);
    check("t6_req", 32'(imem_req), 32'd0);
    step();
    read_reg(2'd1, v);
    check("t6_r1_held", 32'(v), 32'd0);
    reset_n = 1'b1;
    step();
    check("t6_fetch", 32'(imem_req), 32'd1);
    read_pc(v);
    check("t6_pc", 32'(v), 32'd0);

    // 16-bit, 8-register instance: LDI r7,0xFFFF; ADD r7,r7
    run16({3'd1, 3'd7, 3'd0, 16'hFFFF});
    #1;
    check("u16_ldi", 32'(value16), 32'hFFFF);
    run16({3'd3, 3'd7, 3'd7, 16'h0000});
    #1;
    check("u16_add", 32'(value16), 32'hFFFE);
    check("u16_c", 32'(c16), 32'd1);
    check("u16_z", 32'(z16), 32'd0);
    check("u16_halted", 32'(halted16), 32'd0);
    sel16 = 1'b1;
    #1;
    check("u16_pc", 32'(value16), 32'd2);
    check("u16_addr", 32'(addr16), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
